// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_mem_pkg
// Brief    : Size encodings, responder FSM states and byte-enable helper.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Little-endian lanes: lane k carries bits [8k+7:8k].
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_responder_if
// Brief     : Request/response bundle between the CPU memory port and responder.
// Revision  : 1.0 - initial release
// ============================================================================
interface mem_responder_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, size, addr, wdata,
        input  ready, ack, err, rdata
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output ready, ack, err, rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_ram
// Brief    : DEPTH x 32 single-port RAM, four byte-lane write strobes, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // One narrow array per lane keeps each strobe a plain write enable.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_en) begin
                if (i_be[k]) begin
                    r_mem[i_addr] <= i_wdata[8*k +: 8];
                end
                r_q <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*k +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Multi-cycle memory responder with programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int          c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_addr_limit = 32'(4 * DEPTH);
    localparam logic [3:0]  c_last_wait  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam bit          c_zero_lat   = (LATENCY == 0);

    state_e      r_state;
    logic        r_ready;
    logic        r_ack;
    logic        r_err;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;

    logic        w_cur_we;
    logic [1:0]  w_cur_size;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic        w_misalign;
    logic        w_err;
    logic        w_enter_resp;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_ram_q;

    // With zero wait states the access happens on the accepting edge, so the
    // live bus is used while idle and the latched copy otherwise.
    always_comb begin
        w_cur_we    = r_we;
        w_cur_size  = r_size;
        w_cur_addr  = r_addr;
        w_cur_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_cur_we    = bus.we;
            w_cur_size  = bus.size;
            w_cur_addr  = bus.addr;
            w_cur_wdata = bus.wdata;
        end

        w_misalign = 1'b0;
        case (w_cur_size)
            SZ_WORD: w_misalign = |w_cur_addr[1:0];
            SZ_HALF: w_misalign = w_cur_addr[0];
            SZ_BYTE: w_misalign = 1'b0;
            default: w_misalign = 1'b1;
        endcase
        w_err = w_misalign || (w_cur_addr >= c_addr_limit);

        w_enter_resp = ((r_state == ST_IDLE) && bus.req && c_zero_lat)
                    || ((r_state == ST_WAIT) && (r_cnt == c_last_wait));

        w_wdata_rep = w_cur_wdata;
        case (w_cur_size)
            SZ_HALF: w_wdata_rep = {2{w_cur_wdata[15:0]}};
            SZ_BYTE: w_wdata_rep = {4{w_cur_wdata[7:0]}};
            default: w_wdata_rep = w_cur_wdata;
        endcase

        w_be = (w_cur_we && !w_err) ? byte_en(w_cur_size, w_cur_addr[1:0]) : 4'b0000;
    end

    mem_resp_ram #(
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_enter_resp),
        .i_be    (w_be),
        .i_addr  (w_cur_addr[c_aw+1:2]),
        .i_wdata (w_wdata_rep),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= SZ_WORD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_size  <= bus.size;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        if (c_zero_lat) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_last_wait) begin
                        r_state <= ST_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= w_err;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.rdata = (r_ack && !r_err && !r_we) ? w_ram_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Scoreboard bench over four responders with different wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import cpu_mem_pkg::*;

    localparam int NDUT  = 4;
    localparam int DEPTH = 256;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            2:       return 1;
            default: return 15;
        endcase
    endfunction

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_d   [NDUT];
    logic        we_d    [NDUT];
    logic [1:0]  size_d  [NDUT];
    logic [31:0] addr_d  [NDUT];
    logic [31:0] wdata_d [NDUT];
    logic        ready_m [NDUT];
    logic        ack_m   [NDUT];
    logic        err_m   [NDUT];
    logic [31:0] rdata_m [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder_if bus ();
        assign bus.req    = req_d[g];
        assign bus.we     = we_d[g];
        assign bus.size   = size_d[g];
        assign bus.addr   = addr_d[g];
        assign bus.wdata  = wdata_d[g];
        assign ready_m[g] = bus.ready;
        assign ack_m[g]   = bus.ack;
        assign err_m[g]   = bus.err;
        assign rdata_m[g] = bus.rdata;

        mem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (lat_of(g))
        ) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus.slave)
        );
    end

    exp_t        sb  [NDUT][$];
    logic [31:0] mdl [NDUT][DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          prev_ack [NDUT];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed little-endian memory, n bytes starting at addr.
    task automatic model_access(input int k, input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
        int nb;
        int idx;
        logic [31:0] word;
        nb  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        idx = int'(a >> 2);
        e   = (sz == 2'd3) || ((a % nb) != 0) || (idx >= DEPTH);
        rd  = 32'h0;
        if (!e) begin
            word = mdl[k][idx];
            if (w) begin
                for (int b = 0; b < nb; b++) begin
                    word[8*(int'(a % 4) + b) +: 8] = wd[8*b +: 8];
                end
                mdl[k][idx] = word;
            end
            rd = word;
        end
    endtask

    task automatic wait_ready(input int k, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_m[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = ready_m[k];
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout dut%0d: got ready=0 expected 1", k);
        end
    endtask

    task automatic drive_push(input int k, input logic w, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
        exp_t        ex;
        logic        e;
        logic [31:0] rd;
        model_access(k, w, sz, a, wd, e, rd);
        ex.we    = w;
        ex.err   = e;
        ex.rdata = rd;
        ex.acc   = cyc;
        sb[k].push_back(ex);
        req_d[k]   = 1'b1;
        we_d[k]    = w;
        size_d[k]  = sz;
        addr_d[k]  = a;
        wdata_d[k] = wd;
    endtask

    task automatic issue(input int k, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        wait_ready(k, ok);
        if (ok) begin
            drive_push(k, w, sz, a, wd);
            @(negedge clk);
            req_d[k] = 1'b0;
        end
    endtask

    // Keeps a junk write asserted through WAIT/RESP; it must be ignored.
    task automatic issue_with_junk(input int k, input logic [31:0] a);
        bit ok;
        wait_ready(k, ok);
        if (ok) begin
            drive_push(k, 1'b0, SZ_WORD, a, 32'h0);
            for (int i = 0; i <= lat_of(k); i++) begin
                @(negedge clk);
                check("ready_busy", k, {31'h0, ready_m[k]}, 32'h0);
                we_d[k]    = 1'b1;
                wdata_d[k] = 32'hBAD0_0000 | 32'(i);
            end
            req_d[k] = 1'b0;
        end
    endtask

    task automatic stream_reads(input int k, input int n, input logic [31:0] a);
        bit ok;
        int got;
        int last;
        int t;
        wait_ready(k, ok);
        got  = 0;
        last = -1;
        t    = 0;
        while (ok && got < n && t < 500) begin
            if (ready_m[k]) begin
                if (last >= 0) check("accept_gap", k, 32'(cyc - last), 32'(lat_of(k) + 2));
                last = cyc;
                drive_push(k, 1'b0, SZ_WORD, a, 32'h0);
                got++;
            end
            @(negedge clk);
            t++;
        end
        req_d[k] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (t < 200 && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < NDUT; k++) check("drain_pending", k, 32'(sb[k].size()), 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever a responder acknowledges.
    always @(negedge clk) begin
        exp_t ex;
        for (int k = 0; k < NDUT; k++) begin
            if (ack_m[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack dut%0d: got ack=1 expected 0", k);
                end else begin
                    ex = sb[k].pop_front();
                    check("err", k, {31'h0, err_m[k]}, {31'h0, ex.err});
                    if (ex.err || !ex.we) check("rdata", k, rdata_m[k], ex.rdata);
                    check("latency", k, 32'(cyc) - ex.acc, 32'(lat_of(k) + 1));
                end
            end else if (prev_ack[k]) begin
                check("err_after_ack", k, {31'h0, err_m[k]}, 32'h0);
                check("rdata_after_ack", k, rdata_m[k], 32'h0);
            end
            prev_ack[k] = (ack_m[k] === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        bit          ok;
        int          idx;
        logic [1:0]  sz;
        logic [31:0] a;

        for (int k = 0; k < NDUT; k++) begin
            req_d[k] = 1'b0; we_d[k] = 1'b0; size_d[k] = SZ_WORD;
            addr_d[k] = 32'h0; wdata_d[k] = 32'h0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("reset_ready", k, {31'h0, ready_m[k]}, 32'h1);
            check("reset_ack",   k, {31'h0, ack_m[k]},   32'h0);
            check("reset_err",   k, {31'h0, err_m[k]},   32'h0);
            check("reset_rdata", k, rdata_m[k],          32'h0);
        end
        rst_n = 1'b1;

        // Known contents for the low words and the top-of-memory words.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 20; i++) begin
                idx = (i < 16) ? i : (DEPTH - 20 + i);
                issue(k, 1'b1, SZ_WORD, 32'(idx * 4), $urandom);
            end
        end

        issue(0, 1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF);
        issue(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        issue(0, 1'b1, SZ_BYTE, 32'h12, 32'h0000_0055);
        issue(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        issue(0, 1'b1, SZ_HALF, 32'h10, 32'h0000_A0B1);
        issue(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        issue(0, 1'b0, SZ_WORD, 32'h13, 32'h0);
        issue(0, 1'b1, SZ_HALF, 32'h11, 32'h0000_FFFF);
        issue(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        issue(0, 1'b0, SZ_WORD, 32'(4 * DEPTH), 32'h0);
        issue(0, 1'b0, SZ_WORD, 32'(4 * DEPTH - 4), 32'h0);
        issue(0, 1'b0, SZ_RSVD, 32'h10, 32'h0);
        issue(0, 1'b0, SZ_BYTE, 32'(4 * DEPTH - 1), 32'h0);

        issue_with_junk(0, 32'h4);
        issue_with_junk(3, 32'h4);
        issue(0, 1'b0, SZ_WORD, 32'h4, 32'h0);
        issue(3, 1'b0, SZ_WORD, 32'h4, 32'h0);

        stream_reads(1, 6, 32'h10);
        stream_reads(2, 4, 32'h8);
        drain();

        // Reset pulsed while a write sits in WAIT: it must be dropped.
        saved = mdl[0][8];
        wait_ready(0, ok);
        if (ok) begin
            req_d[0] = 1'b1; we_d[0] = 1'b1; size_d[0] = SZ_WORD;
            addr_d[0] = 32'h20; wdata_d[0] = 32'h1234_5678;
            @(negedge clk);
            req_d[0] = 1'b0;
            check("wait_ready_low", 0, {31'h0, ready_m[0]}, 32'h0);
            rst_n = 1'b0;
            #1;
            check("midreset_ready", 0, {31'h0, ready_m[0]}, 32'h1);
            check("midreset_ack",   0, {31'h0, ack_m[0]},   32'h0);
            check("midreset_err",   0, {31'h0, err_m[0]},   32'h0);
            check("midreset_rdata", 0, rdata_m[0],          32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            mdl[0][8] = saved;
        end
        issue(0, 1'b0, SZ_WORD, 32'h20, 32'h0);

        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 30; n++) begin
                idx = int'($urandom_range(0, 19));
                idx = (idx < 16) ? idx : (DEPTH - 20 + idx);
                a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
                sz  = ($urandom_range(0, 9) == 0) ? SZ_RSVD : 2'($urandom_range(0, 2));
                issue(k, 1'($urandom_range(0, 1)), sz, a, $urandom);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's data/instruction port. It accepts one request at a time over a valid/ready handshake. It holds the request for a programmable number of wait states, then performs a word, halfword or byte access against internal storage. It returns the aligned word or an error with a one-cycle acknowledge. It replaces the zero-latency memory model so that the control unit's fetch and load/store states can be exercised against real multi-cycle latency.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words of storage; byte address space is 0 .. 4*DEPTH-1
- LATENCY, 2, wait-state cycles between acceptance and response (0..15)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low; clears the FSM and outputs, not storage
- req  in  1  request valid
- we  in  1  1 = write, 0 = read; sampled with req
- size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as error)
- addr  in  32  byte address
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- ready  out  1  responder idle and able to accept; reset value 1
- ack  out  1  one-cycle response strobe; reset value 0
- err  out  1  valid with ack: misaligned, out of range or reserved size; reset value 0
- rdata  out  32  aligned word containing the addressed location, valid with ack on reads; reset value 0

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ready=1.
  - When req=1, latch we/size/addr/wdata and clear the wait counter.
  - Go to WAIT if LATENCY>0, else go to RESP.
- WAIT:
  - ready=0.
  - The counter increments each cycle.
  - When the counter reaches LATENCY-1, go to RESP.
- RESP:
  - ack=1 for exactly one cycle; ready=0.
  - Next state is IDLE.
- Error check on the latched request:
  - err=1 if size=11.
  - err=1 if word and addr[1:0]!=0, or halfword and addr[0]!=0.
  - err=1 if addr >= 4*DEPTH.
  - On error: no write, rdata=0.
- Write:
  - Byte lanes are little-endian; lane k holds bits [8k+7:8k].
  - Byte enables: word 1111; half 0011 or 1100 by addr[1]; byte one-hot by addr[1:0].
  - Write data is replicated into the selected lanes: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}.
  - The write commits on the clock edge that enters RESP.
- Read:
  - rdata is the full word at addr[31:2], whatever the size.
  - Extraction and extension are done downstream by the CPU's load-size logic.
- Requests are ignored while ready=0. req held high after RESP is accepted as a new request in the following IDLE cycle.

## Timing
- Request accepted at edge N (req=1, ready=1).
- ack is high during cycle N+1+LATENCY. With LATENCY=0, ack is in cycle N+1.
- Throughput: one request per LATENCY+2 cycles.
- rdata and err are registered, valid only while ack=1, and return to 0 the cycle after.
- Read-after-write to the same word returns the new data, because the write commits before the later access.
- Reset asserted mid-transaction:
  - Takes effect immediately: IDLE, ready=1, ack=0, err=0, rdata=0.
  - A pending write that has not reached RESP is discarded.
  - Storage is not cleared.

## Structure
- Shared package cpu_mem_pkg:
  - size encodings SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD
  - FSM state enum
  - a function computing byte enables from size and addr[1:0]
- Sub-module mem_resp_ram: DEPTH×32 synchronous single-port array with 4 byte-enable write strobes and registered read. It is instantiated once.
- The top block holds the FSM, wait counter, request latches, error check and lane replication.

## Test plan
- Aligned word: LATENCY=2. Write 0xDEADBEEF to 0x10, then read 0x10 → ack in cycle N+3, rdata=0xDEADBEEF, err=0.
- Byte store: after the above, byte write 0x55 to 0x12 → read 0x10 returns 0xDE55BEEF. Halfword write 0xA0B1 to 0x10 → 0xDE55A0B1.
- Misaligned and range errors: word read at 0x13 → err=1, rdata=0. Half write to 0x11 → err=1 and the word is unchanged. Address 4*DEPTH → err=1.
- Handshake:
  - req held high continuously with LATENCY=0 → ack every 2nd cycle.
  - ready=0 in WAIT/RESP; requests presented then are not accepted.
- Reset mid-WAIT: a write to 0x20 is accepted, then reset is pulsed low in WAIT → ready=1 and ack=0 immediately. A later read of 0x20 returns the prior contents.
- LATENCY sweep 0, 1, 15: ack latency measured as exactly LATENCY+1 cycles after acceptance.
